ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the other direction of the existing ps2_keyboard receiver, on the same open-drain clock/data pair.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset: inhibit clock, drive start bit, shift 8 data + odd parity + stop on device-generated clock, check device ACK.
- Sits beside ps2_keyboard in the SoC top. `busy` lets the top hold the receiver (clrn / nextdata_n) off during a transmission.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, max clk cycles between consecutive device clock falling edges, and for the final bus-idle wait (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; byte is accepted when tx_valid & tx_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: frame sent and ACK seen.
- ack_err  out  1  one-cycle pulse: data line high at the ACK edge.
- timeout  out  1  one-cycle pulse: device clock stalled.
- ps2_clk_i  in  1  raw pin level of the PS/2 clock.
- ps2_data_i  in  1  raw pin level of the PS/2 data.
- ps2_clk_oe  out  1  1 = pull clock low; 0 = release.
- ps2_data_oe  out  1  1 = pull data low; 0 = release.

Behaviour:
- Reset (clrn low, asynchronous): state IDLE; ps2_clk_oe=0, ps2_data_oe=0; busy=0, tx_ready=1 after reset; done/ack_err/timeout=0; counters and shift register cleared.
- Reset mid-frame: both lines released immediately; no pulses are issued.
- Input synchronization: ps2_clk_i and ps2_data_i each pass through a 2-FF synchronizer.
- Falling-edge detection: fall = registered previous synced clock & ~current synced clock. A pin edge produces `fall` 3 clk cycles later.
- Accept: in IDLE, tx_valid & tx_ready latches {parity, tx_data}, parity = ~^tx_data (odd), and moves to INHIBIT on the next cycle. tx_valid outside IDLE is ignored.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. ps2_data_oe goes to 1 in the last inhibit cycle (start bit).
- START: ps2_clk_oe=0, ps2_data_oe stays 1; the bit counter starts at 0.
- Falling edges, counted from the first edge after START:
  - Edges 1..8: ps2_data_oe = ~tx_data[n-1], LSB first.
  - Edge 9: ps2_data_oe = ~parity.
  - Edge 10: ps2_data_oe = 0 (stop bit / release); go to ACK.
- ACK: on edge 11, sample synced data.
  - 0: go to WAIT_IDLE.
  - 1: pulse ack_err, go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clock=1 and synced data=1 on the same cycle. Then pulse done only if no ack_err was raised in this frame, and go to IDLE.
- Timeout: a counter is cleared on entering START and on every fall, and counts in START, DATA, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES: release both lines, pulse timeout, go to IDLE. No done or ack_err for that frame.
- Priority in the same cycle: clrn > timeout > fall processing.
- Pulse exclusivity: exactly one of done, ack_err, timeout fires per accepted byte. Exception: after an ack_err, a later timeout in WAIT_IDLE still fires timeout.
- Registered outputs: all outputs come from flops; no combinational path from ps2_*_i to outputs.
- Latency: INHIBIT_CYCLES + 1 cycles from accept to release of ps2_clk_oe.

Decomposition:
- Shared package ps2_pkg:
  - state encoding IDLE, INHIBIT, START, DATA, ACK, WAIT_IDLE;
  - PS2_FRAME_EDGES=11, PS2_DATA_BITS=8.
- Sub-module ps2_sync_edge (2-FF synchronizer + falling-edge detector). It is reused for both pins here and can later be shared with ps2_keyboard.

Test Plan:
Bench uses INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200, and a device model that clocks the line at 40-cycle period and drives ACK low at edge 11.
- Send 0xED -> ps2_clk_oe high exactly 8 cycles; bits sampled at device rising edges = 0,1,0,1,1,0,1,1,1 (start, LSB-first data), parity 1, stop 1; done pulses once; tx_ready=0 throughout, 1 after.
- Send 0x01 -> parity 0. Send 0x00 and 0xFF -> parity 1. Frames back-to-back with tx_valid held high -> second byte accepted only after done.
- Device omits ACK (data high at edge 11) -> ack_err pulses once, no done, returns to IDLE once the bus is idle.
- Device never clocks after START -> timeout pulse 200 cycles after START entry; ps2_clk_oe=ps2_data_oe=0; busy=0.
- clrn low after edge 4 -> oe outputs 0 in the same cycle, no pulses; a subsequent send of 0xF4 completes normally.
- tx_valid pulsed during DATA with 0x55 -> ignored; the in-flight byte is unchanged and only one done is seen.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, frame geometry and parity helper.
// Intended to be imported by both the host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    DATA,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam int PS2_FRAME_EDGES = 11;
  localparam int PS2_DATA_BITS   = 8;

  // Device clock edge on which the host releases data (stop bit).
  localparam logic [3:0] PS2_STOP_EDGE = 4'(PS2_FRAME_EDGES - 1);

  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer plus falling-edge detector for one PS/2 pin.
// Flops reset to 1 so an idle (pulled-up) bus never reports a spurious edge.
module ps2_sync_edge (
  input  logic clk,
  input  logic clrn,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, drives the start bit, then shifts
// data, odd parity and stop on device clock falls and checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IW-1:0] C_INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] C_INH_PRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic w_clk_s;
  logic w_clk_fall;
  logic w_data_s;
  logic w_data_fall_unused;

  ps2_sync_edge u_clk_sync (
    .clk     (clk),
    .clrn    (clrn),
    .i_pin   (ps2_clk_i),
    .o_level (w_clk_s),
    .o_fall  (w_clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk     (clk),
    .clrn    (clrn),
    .i_pin   (ps2_data_i),
    .o_level (w_data_s),
    .o_fall  (w_data_fall_unused)
  );

  ps2_tx_state_t            r_state;
  logic [PS2_DATA_BITS:0]   r_shift;
  logic [IW-1:0]            r_cnt;
  logic [TW-1:0]            r_tmo;
  logic [3:0]               r_bit;
  logic                     r_err_seen;
  logic                     r_clk_oe;
  logic                     r_data_oe;
  logic                     r_tx_ready;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_ack_err;
  logic                     r_timeout;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_bit      <= '0;
      r_err_seen <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ack_err  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_timeout <= 1'b0;

      // A stalled device clock aborts the frame ahead of any edge seen this cycle.
      if ((r_state inside {START, DATA, ACK, WAIT_IDLE}) && (r_tmo == C_TMO_LAST)) begin
        r_state    <= IDLE;
        r_clk_oe   <= 1'b0;
        r_data_oe  <= 1'b0;
        r_tx_ready <= 1'b1;
        r_busy     <= 1'b0;
        r_timeout  <= 1'b1;
        r_tmo      <= '0;
      end else begin
        if (r_state inside {START, DATA, ACK, WAIT_IDLE}) begin
          r_tmo <= w_clk_fall ? '0 : r_tmo + 1'b1;
        end

        case (r_state)
          IDLE: begin
            if (tx_valid && r_tx_ready) begin
              r_shift    <= {odd_parity(tx_data), tx_data};
              r_state    <= INHIBIT;
              r_clk_oe   <= 1'b1;
              r_cnt      <= '0;
              r_tx_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_err_seen <= 1'b0;
            end
          end

          INHIBIT: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_INH_PRE) begin
              r_data_oe <= 1'b1;
            end
            if (r_cnt == C_INH_LAST) begin
              r_clk_oe <= 1'b0;
              r_state  <= START;
              r_bit    <= '0;
              r_tmo    <= '0;
            end
          end

          // r_bit counts device edges already seen; data and parity shift out LSB first.
          START, DATA: begin
            if (w_clk_fall) begin
              r_bit   <= r_bit + 1'b1;
              r_state <= DATA;
              if (r_bit == PS2_STOP_EDGE - 4'd1) begin
                r_data_oe <= 1'b0;
                r_state   <= ACK;
              end else begin
                r_data_oe <= ~r_shift[0];
                r_shift   <= {1'b0, r_shift[PS2_DATA_BITS:1]};
              end
            end
          end

          ACK: begin
            if (w_clk_fall) begin
              r_state <= WAIT_IDLE;
              if (w_data_s) begin
                r_ack_err  <= 1'b1;
                r_err_seen <= 1'b1;
              end
            end
          end

          WAIT_IDLE: begin
            if (w_clk_s && w_data_s) begin
              r_done     <= ~r_err_seen;
              r_state    <= IDLE;
              r_tx_ready <= 1'b1;
              r_busy     <= 1'b0;
            end
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready    = r_tx_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign ack_err     = r_ack_err;
  assign timeout     = r_timeout;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a simple keyboard model
// clocking at a 40-cycle period.
module tb_ps2_host_tx;

  logic       clk;
  logic       clrn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  logic dev_clk_low;
  logic dev_data_low;

  int n_tests;
  int n_fail;
  int n_done;
  int n_ack;
  int n_tmo;
  int n_inh;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (8),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout     (timeout),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (done === 1'b1)       n_done++;
    if (ack_err === 1'b1)    n_ack++;
    if (timeout === 1'b1)    n_tmo++;
    if (ps2_clk_oe === 1'b1) n_inh++;
  endtask

  task automatic clear_counts();
    n_done = 0;
    n_ack  = 0;
    n_tmo  = 0;
    n_inh  = 0;
  endtask

  task automatic start_tx(input logic [7:0] b);
    clear_counts();
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // Keyboard model: samples the line while its clock is high, ACKs edge 11 if asked.
  task automatic dev_frame(input bit do_ack, input int inject_edge, output logic [10:0] s);
    int w;
    s = '0;
    w = 0;
    while (ps2_clk_oe !== 1'b1 && w < 20) begin tick(); w++; end
    check("inhibit_start", 32'(ps2_clk_oe), 32'd1);
    check("busy_in_frame", 32'({tx_ready, busy}), 32'h1);
    w = 0;
    while (ps2_clk_oe !== 1'b0 && w < 50) begin tick(); w++; end
    check("inhibit_release", 32'(ps2_clk_oe), 32'd0);
    repeat (20) tick();
    s[0] = ps2_data_i;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      for (int j = 0; j < 20; j++) begin
        if (k == inject_edge && j == 5) begin tx_data = 8'h55; tx_valid = 1'b1; end
        if (k == inject_edge && j == 6) tx_valid = 1'b0;
        tick();
      end
      dev_clk_low = 1'b0;
      if (k <= 10) s[k] = ps2_data_i;
      repeat (10) tick();
      if (k == 10 && do_ack) dev_data_low = 1'b1;
      repeat (10) tick();
    end
    dev_data_low = 1'b0;
    w = 0;
    while (tx_ready !== 1'b1 && w < 200) begin tick(); w++; end
    check("frame_end_ready", 32'(tx_ready), 32'd1);
  endtask

  logic [10:0] s;
  int          w;

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    clear_counts();
    clrn         = 1'b0;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) tick();
    check("rst_outputs", 32'({tx_ready, busy, done, ack_err, timeout, ps2_clk_oe, ps2_data_oe}), 32'h40);
    clrn = 1'b1;
    repeat (3) tick();
    check("post_rst_ready", 32'({tx_ready, busy}), 32'h2);

    // 0xED set-LEDs: 6 ones -> parity 1
    start_tx(8'hED);
    dev_frame(1'b1, 0, s);
    check("ed_frame", 32'(s), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
    check("ed_start_bit", 32'(s[0]), 32'd0);
    check("ed_inhibit_len", 32'(n_inh), 32'd8);
    check("ed_done", 32'(n_done), 32'd1);
    check("ed_no_err", 32'(n_ack + n_tmo), 32'd0);
    check("ed_idle", 32'({tx_ready, busy, ps2_clk_oe, ps2_data_oe}), 32'h8);
    $display("[TB] frame 0xED sampled %b done=%0d", s, n_done);

    // Back-to-back with tx_valid held: 0x01 (parity 0), 0x00 (1), 0xFF (1)
    clear_counts();
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    dev_frame(1'b1, 0, s);
    check("b2b_01_frame", 32'(s), 32'({1'b1, 1'b0, 8'h01, 1'b0}));
    check("b2b_01_done", 32'(n_done), 32'd1);
    check("b2b_01_inhibit", 32'(n_inh), 32'd8);
    $display("[TB] frame 0x01 sampled %b done=%0d", s, n_done);
    clear_counts();
    tx_data = 8'h00;
    dev_frame(1'b1, 0, s);
    check("b2b_00_frame", 32'(s), 32'({1'b1, 1'b1, 8'h00, 1'b0}));
    check("b2b_00_done", 32'(n_done), 32'd1);
    check("b2b_00_inhibit", 32'(n_inh), 32'd8);
    $display("[TB] frame 0x00 sampled %b done=%0d", s, n_done);
    clear_counts();
    tx_data = 8'hFF;
    dev_frame(1'b1, 0, s);
    tx_valid = 1'b0;
    check("b2b_ff_frame", 32'(s), 32'({1'b1, 1'b1, 8'hFF, 1'b0}));
    check("b2b_ff_done", 32'(n_done), 32'd1);
    repeat (20) tick();
    check("b2b_ff_no_extra", 32'(n_inh), 32'd8);
    $display("[TB] frame 0xFF sampled %b done=%0d", s, n_done);

    // Device omits ACK
    start_tx(8'hED);
    dev_frame(1'b0, 0, s);
    repeat (5) tick();
    check("noack_ack_err", 32'(n_ack), 32'd1);
    check("noack_no_done", 32'(n_done + n_tmo), 32'd0);
    check("noack_idle", 32'({tx_ready, busy}), 32'h2);
    $display("[TB] no-ack frame ack_err=%0d done=%0d", n_ack, n_done);

    // Device never clocks after START
    start_tx(8'hAA);
    w = 0;
    while (ps2_clk_oe !== 1'b0 && w < 50) begin tick(); w++; end
    w = 0;
    while (timeout !== 1'b1 && w < 400) begin tick(); w++; end
    check("tmo_latency", 32'(w), 32'd200);
    check("tmo_released", 32'({ps2_clk_oe, ps2_data_oe, busy, tx_ready}), 32'h1);
    repeat (5) tick();
    check("tmo_once", 32'(n_tmo), 32'd1);
    check("tmo_no_other", 32'(n_done + n_ack), 32'd0);
    $display("[TB] stalled device timeout after %0d cycles", w);

    // Reset after edge 4 of 0x12 (bit3 = 0 -> data pulled low)
    start_tx(8'h12);
    w = 0;
    while (ps2_clk_oe !== 1'b0 && w < 50) begin tick(); w++; end
    repeat (20) tick();
    for (int k = 1; k <= 4; k++) begin
      dev_clk_low = 1'b1;
      repeat (20) tick();
      if (k < 4) begin
        dev_clk_low = 1'b0;
        repeat (20) tick();
      end
    end
    check("rst_mid_data_oe", 32'(ps2_data_oe), 32'd1);
    clrn = 1'b0;
    #1;
    check("rst_mid_async", 32'({ps2_clk_oe, ps2_data_oe, busy, tx_ready}), 32'h1);
    tick();
    dev_clk_low = 1'b0;
    repeat (3) tick();
    clrn = 1'b1;
    repeat (30) tick();
    check("rst_mid_no_pulse", 32'(n_done + n_ack + n_tmo), 32'd0);
    $display("[TB] reset mid-frame, pulses=%0d", n_done + n_ack + n_tmo);
    start_tx(8'hF4);
    dev_frame(1'b1, 0, s);
    check("f4_frame", 32'(s), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
    check("f4_done", 32'(n_done), 32'd1);
    $display("[TB] frame 0xF4 sampled %b done=%0d", s, n_done);

    // tx_valid with 0x55 during DATA must be ignored
    start_tx(8'h3C);
    dev_frame(1'b1, 3, s);
    repeat (30) tick();
    check("inj_frame", 32'(s), 32'({1'b1, 1'b1, 8'h3C, 1'b0}));
    check("inj_one_done", 32'(n_done), 32'd1);
    check("inj_no_reaccept", 32'(n_inh), 32'd8);
    $display("[TB] frame 0x3C with injected 0x55 sampled %b done=%0d", s, n_done);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
